// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline control unit: FSM state, register-index
// type, control-word layout and the canonical control words.
package cpu_types_pkg;

   typedef logic [4:0] regbits_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DWAIT  = 2'd1,
      HALTED = 2'd2
   } pcu_state_t;

   localparam logic [7:0] DWAIT_TIMEOUT = 8'd255;

   // Latch enables and bubble inserts, in pipeline order.
   typedef struct packed {
      logic pc_en;
      logic en_fd;
      logic en_de;
      logic en_ex;
      logic en_me;
      logic flush_fd;
      logic flush_de;
      logic flush_ex;
   } pcu_ctrl_t;

   localparam pcu_ctrl_t CTRL_NORMAL = pcu_ctrl_t'(8'b11111_000);
   localparam pcu_ctrl_t CTRL_RESET  = pcu_ctrl_t'(8'b00000_111);
   localparam pcu_ctrl_t CTRL_HOLD   = pcu_ctrl_t'(8'b00000_000);
   localparam pcu_ctrl_t CTRL_REDIR  = pcu_ctrl_t'(8'b11111_111);
   localparam pcu_ctrl_t CTRL_JUMP   = pcu_ctrl_t'(8'b11111_100);
   localparam pcu_ctrl_t CTRL_LDUSE  = pcu_ctrl_t'(8'b00011_001);
   localparam pcu_ctrl_t CTRL_IMISS  = pcu_ctrl_t'(8'b00111_010);

endpackage

// File: rtl/pipeline_control_unit_if.sv
// Hazard/status inputs and stage-control outputs of the pipeline control unit.
interface pipeline_control_unit_if;
   import cpu_types_pkg::*;

   logic        ihit;
   logic        dhit;
   logic        dREN_me;
   logic        dWEN_me;
   logic        memRead_ex;
   regbits_t    regDst_ex;
   regbits_t    rs_de;
   regbits_t    rt_de;
   logic        usesRt_de;
   logic        jr_de;
   logic        jump_de;
   logic        brTaken_me;
   logic        halt_me;

   logic        pc_en;
   logic        en_fd;
   logic        en_de;
   logic        en_ex;
   logic        en_me;
   logic        flush_fd;
   logic        flush_de;
   logic        flush_ex;
   logic        halt;
   logic        dmem_busy;
   logic        timeout_err;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   modport pcu (
      input  ihit, dhit, dREN_me, dWEN_me, memRead_ex, regDst_ex, rs_de, rt_de,
             usesRt_de, jr_de, jump_de, brTaken_me, halt_me,
      output pc_en, en_fd, en_de, en_ex, en_me, flush_fd, flush_de, flush_ex,
             halt, dmem_busy, timeout_err, stall_cnt, flush_cnt
   );

   modport tb (
      output ihit, dhit, dREN_me, dWEN_me, memRead_ex, regDst_ex, rs_de, rt_de,
             usesRt_de, jr_de, jump_de, brTaken_me, halt_me,
      input  pc_en, en_fd, en_de, en_ex, en_me, flush_fd, flush_de, flush_ex,
             halt, dmem_busy, timeout_err, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/sat_counter16.sv
// 16-bit event counter with synchronous clear that sticks at all-ones.
module sat_counter16 (
   input  logic        clk_i,
   input  logic        clr_i,
   input  logic        inc_i,
   output logic [15:0] cnt_o
);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   // Next count: step on inc_i unless already saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // Count register, cleared synchronously.
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipeline control unit: arbitrates dmem wait, redirects, load-use and imem
// miss into per-stage enables/flushes, tracks halt and dmem-wait timeout.
module pipeline_control_unit
   import cpu_types_pkg::*;
(
   input logic                  CLK,
   input logic                  RST,
   pipeline_control_unit_if.pcu bus
);

   pcu_state_t state_q;
   pcu_state_t state_d;
   logic [7:0] wait_cnt_q;
   logic [7:0] wait_cnt_d;
   logic       timeout_q;
   logic       timeout_d;
   pcu_ctrl_t  ctrl;
   logic       busy;
   logic       stall_inc;
   logic       flush_inc;
   logic       dmem_wait;
   logic       load_use;

   assign dmem_wait = (bus.dREN_me | bus.dWEN_me) & ~bus.dhit;

   // JR needs rs in DE itself, so it hazards even against a $0 destination.
   assign load_use = bus.memRead_ex &
                     (((bus.regDst_ex != '0) &
                       ((bus.rs_de == bus.regDst_ex) |
                        (bus.usesRt_de & (bus.rt_de == bus.regDst_ex)))) |
                      (bus.jr_de & (bus.rs_de == bus.regDst_ex)));

   // Next state, control word and counter strobes, in priority order.
   always_comb begin
      state_d    = state_q;
      ctrl       = CTRL_NORMAL;
      busy       = 1'b0;
      stall_inc  = 1'b0;
      flush_inc  = 1'b0;
      wait_cnt_d = '0;
      timeout_d  = timeout_q;
      if (RST) begin
         ctrl = CTRL_RESET;
      end else begin
         case (state_q)
            HALTED: begin
               ctrl = CTRL_HOLD;
            end
            DWAIT: begin
               if (bus.dhit) begin
                  state_d = RUN;
               end else begin
                  ctrl       = CTRL_HOLD;
                  busy       = 1'b1;
                  wait_cnt_d = (wait_cnt_q == DWAIT_TIMEOUT) ? DWAIT_TIMEOUT
                                                             : wait_cnt_q + 8'd1;
                  if (wait_cnt_d == DWAIT_TIMEOUT) begin
                     timeout_d = 1'b1;
                  end
               end
            end
            RUN: begin
               if (dmem_wait) begin
                  ctrl    = CTRL_HOLD;
                  busy    = 1'b1;
                  state_d = DWAIT;
               end else begin
                  if (bus.halt_me) begin
                     state_d = HALTED;
                  end
                  if (bus.brTaken_me) begin
                     ctrl      = CTRL_REDIR;
                     flush_inc = 1'b1;
                  end else if (bus.jump_de) begin
                     ctrl      = CTRL_JUMP;
                     flush_inc = 1'b1;
                  end else if (load_use) begin
                     ctrl      = CTRL_LDUSE;
                     stall_inc = 1'b1;
                  end else if (!bus.ihit) begin
                     ctrl = CTRL_IMISS;
                  end
               end
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   // State, dmem-wait counter and sticky timeout flag.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   sat_counter16 u_stall_cnt (
      .clk_i (CLK),
      .clr_i (RST),
      .inc_i (stall_inc),
      .cnt_o (bus.stall_cnt)
   );

   sat_counter16 u_flush_cnt (
      .clk_i (CLK),
      .clr_i (RST),
      .inc_i (flush_inc),
      .cnt_o (bus.flush_cnt)
   );

   assign bus.pc_en       = ctrl.pc_en;
   assign bus.en_fd       = ctrl.en_fd;
   assign bus.en_de       = ctrl.en_de;
   assign bus.en_ex       = ctrl.en_ex;
   assign bus.en_me       = ctrl.en_me;
   assign bus.flush_fd    = ctrl.flush_fd;
   assign bus.flush_de    = ctrl.flush_de;
   assign bus.flush_ex    = ctrl.flush_ex;
   assign bus.dmem_busy   = busy;
   assign bus.halt        = (state_q == HALTED);
   assign bus.timeout_err = timeout_q;

endmodule

// File: doc/pipeline_control_unit.md
PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

Interface
REQ-001 SHALL have ports: CLK  in  1  pipeline clock; RST  in  1  synchronous, active-high reset, sampled on posedge CLK.
REQ-002 SHALL have inputs: ihit 1 imem fetch done; dhit 1 dmem access done; dREN_me, dWEN_me 1 each, MEM-stage memory op; memRead_ex 1 load in EX; regDst_ex 5 EX destination; rs_de, rt_de 5 DE sources; usesRt_de 1 DE reads rt; jr_de 1 JR in DE; jump_de 1 J/JAL in DE; brTaken_me 1 branch resolved taken in MEM; halt_me 1 HALT in MEM.
REQ-003 SHALL have outputs: pc_en 1; en_fd, en_de, en_ex, en_me 1 each, latch enables; flush_fd, flush_de, flush_ex 1 each, bubble insert; halt 1 sticky halted; dmem_busy 1 in DWAIT; timeout_err 1 sticky; stall_cnt 16 load-use stalls; flush_cnt 16 redirect events.

Function
REQ-004 SHALL implement FSM RUN, DWAIT, HALTED; state and counters update only on posedge CLK.
REQ-005 Condition priority SHALL be: HALTED > dmem wait > redirect > load-use > imem miss > normal.
REQ-006 dmem wait = (dREN_me|dWEN_me)&!dhit: pc_en, en_fd, en_de, en_ex, en_me all 0, no flushes; RUN->DWAIT next edge.
REQ-007 In DWAIT with dhit=1 SHALL drive normal-advance outputs that cycle and return to RUN next edge; DWAIT SHALL hold while dhit=0.
REQ-008 SHALL count consecutive DWAIT cycles in an 8-bit counter; reaching 255 SHALL set timeout_err, held until RST; counter clears on leaving DWAIT.
REQ-009 Redirect (brTaken_me=1): pc_en=1 regardless of ihit, all en_*=1, flush_fd=flush_de=flush_ex=1; flush_cnt +1.
REQ-010 Jump (jump_de=1, no brTaken_me): pc_en=1 regardless of ihit, flush_fd=1; flush_cnt +1.
REQ-011 Load-use = memRead_ex & regDst_ex!=0 & (rs_de==regDst_ex | (usesRt_de & rt_de==regDst_ex)); jr_de with rs_de==regDst_ex & memRead_ex also qualifies: pc_en=en_fd=en_de=0, flush_ex=1, en_ex=en_me=1; stall_cnt +1 per cycle.
REQ-012 Imem miss (ihit=0, no higher condition): pc_en=en_fd=0, flush_de=1 (bubble into DE), en_de=en_ex=en_me=1.
REQ-013 Normal: pc_en and all en_* = 1, all flush_* = 0.
REQ-014 halt_me=1 with no dmem wait SHALL move to HALTED next edge; in HALTED all enables and flushes 0, halt=1 until RST.
REQ-015 stall_cnt and flush_cnt SHALL saturate at 16'hFFFF.
REQ-016 Flushes SHALL take effect with the enable in the same cycle (flush wins over hold for the flushed latch).

Reset
REQ-017 On RST=1 at posedge CLK: state RUN, halt=0, timeout_err=0, wait counter 0, stall_cnt=0, flush_cnt=0.
REQ-018 While RST=1 combinational outputs SHALL be: all en_*=0, pc_en=0, all flush_*=1, dmem_busy=0.
REQ-019 RST asserted mid-DWAIT or in HALTED SHALL return to RUN next edge regardless of dhit.

Structure
REQ-020 FSM state enum pcu_state_t and DWAIT_TIMEOUT=8'd255 SHALL live in cpu_types_pkg; register width SHALL use regbits_t.
REQ-021 Interface SHALL be bundled as pipeline_control_unit_if with modports pcu and tb.
REQ-022 One sub-module is natural: sat_counter16 (increment enable, synchronous clear, saturation), instanced twice.
REQ-023 Target size 150-300 lines RTL; no latches; all combinational outputs default-assigned.

Verification
REQ-024 memRead_ex=1, regDst_ex=8, rs_de=8 one cycle -> pc_en=en_fd=en_de=0, flush_ex=1, stall_cnt 0->1.
REQ-025 dREN_me=1, dhit=0 for 3 cycles then 1 -> all en_*=0, dmem_busy=1 for 3 cycles, RUN next edge after dhit, no stall_cnt change.
REQ-026 brTaken_me=1 with ihit=0 and load-use active -> pc_en=1, flush_fd/de/ex=1, flush_cnt +1, stall_cnt unchanged.
REQ-027 dWEN_me=1, dhit=0 held 260 cycles -> timeout_err=1 from 255th DWAIT cycle, stays 1 until RST.
REQ-028 halt_me=1 -> halt=1 next edge, all enables 0; RST=1 one cycle -> halt=0, counters 0, RUN.
REQ-029 Pulse stall condition 70000 cycles -> stall_cnt saturates at 16'hFFFF.
